// File: rtl/spi_xfer_pkg.sv
// -----------------------------------------------------------------------------
// spi_xfer_pkg
// Shared definitions for the spi_xfer_ctrl block: the spi_ms SFR address map,
// control-register bit positions, status-register values, the controller
// state encoding and a helper that assembles the control byte.
// -----------------------------------------------------------------------------
package spi_xfer_pkg;

  // spi_ms SFR addresses
  localparam logic [2:0] SFR_CTL = 3'd0;
  localparam logic [2:0] SFR_STS = 3'd1;
  localparam logic [2:0] SFR_DIV = 3'd2;
  localparam logic [2:0] SFR_DAT = 3'd3;

  // Control register bit positions
  localparam int CTL_SPE  = 6;
  localparam int CTL_MSTR = 4;
  localparam int CTL_CPOL = 3;
  localparam int CTL_CPHA = 2;

  // Status register values: 0x01 enables the core, 0x00 clears the
  // transfer-complete flag (and with it intspi).
  localparam logic [7:0] STS_ENABLE = 8'h01;
  localparam logic [7:0] STS_CLEAR  = 8'h00;

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_CFG_CTL  = 4'd1,
    S_CFG_STS  = 4'd2,
    S_CFG_DIV  = 4'd3,
    S_SS_ON    = 4'd4,
    S_LOAD     = 4'd5,
    S_WR_DAT   = 4'd6,
    S_WAIT_INT = 4'd7,
    S_READ     = 4'd8,
    S_ACK      = 4'd9,
    S_SS_HOLD  = 4'd10,
    S_GAP      = 4'd11
  } state_t;

  // Control byte: SPE and MSTR always set, mode bits from the configuration.
  function automatic logic [7:0] ctl_byte(input logic cpol, input logic cpha);
    logic [7:0] v;
    v           = 8'h00;
    v[CTL_SPE]  = 1'b1;
    v[CTL_MSTR] = 1'b1;
    v[CTL_CPOL] = cpol;
    v[CTL_CPHA] = cpha;
    return v;
  endfunction

endpackage

// File: rtl/spi_rx_fifo.sv
// -----------------------------------------------------------------------------
// spi_rx_fifo
// Synchronous FIFO holding bytes read back from spi_ms until the host pops
// them. Pointers carry one extra MSB so full and empty are told apart without
// a separate count. Push when full and pop when empty are ignored; a push and
// a pop in the same cycle both take effect.
//
// Ports
//   i_clk, i_rst   clock, synchronous active-high reset (flushes contents)
//   i_push, i_data write strobe and byte
//   i_pop          read strobe (advances the read pointer)
//   o_data         byte at the head, valid while o_empty is low
//   o_full/o_empty occupancy flags
// -----------------------------------------------------------------------------
module spi_rx_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 8
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_push,
  input  logic [W-1:0] i_data,
  input  logic         i_pop,
  output logic [W-1:0] o_data,
  output logic         o_full,
  output logic         o_empty
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] r_mem [DEPTH];
  logic [AW:0]  r_wr_ptr;
  logic [AW:0]  r_rd_ptr;
  logic         w_push;
  logic         w_pop;

  // Same index with different wrap bits means the writer is a full lap ahead.
  assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign o_empty = (r_wr_ptr == r_rd_ptr);
  assign o_data  = r_mem[r_rd_ptr[AW-1:0]];

  assign w_push = i_push && !o_full;
  assign w_pop  = i_pop && !o_empty;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr[AW-1:0]] <= i_data;
        r_wr_ptr                <= r_wr_ptr + (AW+1)'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
      end
    end
  end

endmodule

// File: rtl/spi_xfer_ctrl.sv
// -----------------------------------------------------------------------------
// spi_xfer_ctrl
// Drives the SFR port of spi_ms to turn a host byte stream into SPI bursts.
// A cfg_start pulse programs control, status and divider registers; after that
// each burst asserts one slave select, and for every byte writes the data
// register, waits for intspi, reads the received byte into the RX FIFO and
// acknowledges the interrupt. tx_last closes the burst; a minimum idle gap
// with all selects high follows every burst.
//
// Handshakes (tx and rx): a byte moves on a rising clk edge where valid and
// ready are both high. tx_ready depends combinationally on tx_valid and is
// only ever high in the single LOAD cycle that latches the byte; rx_valid
// means rx_data holds the FIFO head and it stays put until popped.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   cfg_start, cfg_cpol, cfg_cpha, cfg_div, cfg_ss, cfg_done
//                            configuration request/values, configured flag
//   tx_valid, tx_ready, tx_data, tx_last    host TX byte stream
//   rx_valid, rx_ready, rx_data             RX FIFO pop port
//   busy, err_timeout        burst in progress, sticky intspi timeout
//   sfraddr_w, sfraddr_r, sfrwe, spidata_i, spssn_i   to spi_ms
//   sfr_data_o, intspi       from spi_ms
//   dbg_state                current controller state
// -----------------------------------------------------------------------------
module spi_xfer_ctrl
  import spi_xfer_pkg::*;
#(
  parameter int RX_DEPTH    = 4,
  parameter int TIMEOUT_CYC = 1024,
  parameter int IDLE_GAP    = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cfg_start,
  input  logic       cfg_cpol,
  input  logic       cfg_cpha,
  input  logic [1:0] cfg_div,
  input  logic [2:0] cfg_ss,
  output logic       cfg_done,
  input  logic       tx_valid,
  output logic       tx_ready,
  input  logic [7:0] tx_data,
  input  logic       tx_last,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic [7:0] rx_data,
  output logic       busy,
  output logic       err_timeout,
  output logic [2:0] sfraddr_w,
  output logic [2:0] sfraddr_r,
  output logic       sfrwe,
  output logic [7:0] spidata_i,
  output logic [7:0] spssn_i,
  input  logic [7:0] sfr_data_o,
  input  logic       intspi,
  output state_t     dbg_state
);

  // One counter serves every timed state; it restarts on each state change.
  localparam int             CW       = $clog2(TIMEOUT_CYC + IDLE_GAP + 1) + 1;
  localparam logic [CW-1:0]  CNT_MAX  = '1;
  localparam logic [CW-1:0]  TO_LAST  = CW'(TIMEOUT_CYC - 1);
  localparam logic [CW-1:0]  GAP_LAST = CW'(IDLE_GAP - 1);

  state_t        r_state;
  state_t        w_next;
  logic [CW-1:0] r_cnt;

  logic       r_cpol;
  logic       r_cpha;
  logic [1:0] r_div;
  logic [2:0] r_ss;
  logic       r_cfg_done;
  logic       r_err;
  logic [7:0] r_tx_byte;
  logic       r_last;
  logic       r_int;

  logic w_two;
  logic w_cfg_accept;
  logic w_tx_accept;
  logic w_timeout;
  logic w_fifo_push;
  logic w_fifo_full;
  logic w_fifo_empty;
  logic w_sel_on;

  // Second cycle of a two-cycle SFR access or select phase.
  assign w_two = (r_cnt == CW'(1));

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    w_next       = r_state;
    w_cfg_accept = 1'b0;
    w_tx_accept  = 1'b0;
    w_timeout    = 1'b0;
    w_fifo_push  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (cfg_start) begin
          w_cfg_accept = 1'b1;
          w_next       = S_CFG_CTL;
        end else if (r_cfg_done && tx_valid) begin
          w_next = S_SS_ON;
        end
      end
      S_CFG_CTL:  if (w_two) w_next = S_CFG_STS;
      S_CFG_STS:  if (w_two) w_next = S_CFG_DIV;
      S_CFG_DIV:  if (w_two) w_next = S_IDLE;
      S_SS_ON:    if (w_two) w_next = S_LOAD;
      S_LOAD: begin
        if (tx_valid) begin
          w_tx_accept = 1'b1;
          w_next      = S_WR_DAT;
        end
      end
      S_WR_DAT:   if (w_two) w_next = S_WAIT_INT;
      S_WAIT_INT: begin
        if (r_int) begin
          w_next = S_READ;
        end else if (r_cnt == TO_LAST) begin
          w_timeout = 1'b1;
          w_next    = S_SS_HOLD;
        end
      end
      S_READ: begin
        // Read address has been held two cycles once r_cnt is nonzero; a full
        // FIFO keeps us here (address still held) rather than dropping data.
        if ((r_cnt != '0) && !w_fifo_full) begin
          w_fifo_push = 1'b1;
          w_next      = S_ACK;
        end
      end
      S_ACK:      if (w_two) w_next = r_last ? S_SS_HOLD : S_LOAD;
      S_SS_HOLD:  if (w_two) w_next = S_GAP;
      S_GAP:      if (r_cnt == GAP_LAST) w_next = S_IDLE;
      default:    w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next;
      if (w_next != r_state) begin
        r_cnt <= '0;
      end else if (r_cnt != CNT_MAX) begin
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Configuration, latched TX byte, sticky error, registered interrupt
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cpol     <= 1'b0;
      r_cpha     <= 1'b0;
      r_div      <= 2'd0;
      r_ss       <= 3'd0;
      r_cfg_done <= 1'b0;
      r_err      <= 1'b0;
      r_tx_byte  <= 8'h00;
      r_last     <= 1'b0;
      r_int      <= 1'b0;
    end else begin
      r_int <= intspi;
      if (w_cfg_accept) begin
        r_cpol     <= cfg_cpol;
        r_cpha     <= cfg_cpha;
        r_div      <= cfg_div;
        r_ss       <= cfg_ss;
        r_cfg_done <= 1'b0;
        r_err      <= 1'b0;
      end else if ((r_state == S_CFG_DIV) && (w_next == S_IDLE)) begin
        r_cfg_done <= 1'b1;
      end
      if (w_timeout) begin
        r_err <= 1'b1;
      end
      if (w_tx_accept) begin
        r_tx_byte <= tx_data;
        r_last    <= tx_last;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // SFR port decode (pure function of the registered state)
  // ---------------------------------------------------------------------------
  always_comb begin
    sfrwe     = 1'b0;
    sfraddr_w = SFR_CTL;
    spidata_i = 8'h00;
    sfraddr_r = SFR_CTL;
    w_sel_on  = 1'b0;
    busy      = 1'b0;
    case (r_state)
      S_CFG_CTL: begin
        sfrwe     = 1'b1;
        sfraddr_w = SFR_CTL;
        spidata_i = ctl_byte(r_cpol, r_cpha);
      end
      S_CFG_STS: begin
        sfrwe     = 1'b1;
        sfraddr_w = SFR_STS;
        spidata_i = STS_ENABLE;
      end
      S_CFG_DIV: begin
        sfrwe     = 1'b1;
        sfraddr_w = SFR_DIV;
        spidata_i = {6'b0, r_div};
      end
      S_SS_ON, S_LOAD, S_WAIT_INT, S_SS_HOLD: begin
        w_sel_on = 1'b1;
        busy     = 1'b1;
      end
      S_WR_DAT: begin
        w_sel_on  = 1'b1;
        busy      = 1'b1;
        sfrwe     = 1'b1;
        sfraddr_w = SFR_DAT;
        spidata_i = r_tx_byte;
      end
      S_READ: begin
        w_sel_on  = 1'b1;
        busy      = 1'b1;
        sfraddr_r = SFR_DAT;
      end
      S_ACK: begin
        w_sel_on  = 1'b1;
        busy      = 1'b1;
        sfrwe     = 1'b1;
        sfraddr_w = SFR_STS;
        spidata_i = STS_CLEAR;
      end
      S_GAP: begin
        busy = 1'b1;
      end
      default: begin
        busy = 1'b0;
      end
    endcase
  end

  always_comb begin
    spssn_i = 8'hFF;
    if (w_sel_on) begin
      spssn_i[r_ss] = 1'b0;
    end
  end

  assign tx_ready    = w_tx_accept;
  assign cfg_done    = r_cfg_done;
  assign err_timeout = r_err;
  assign rx_valid    = !w_fifo_empty;
  assign dbg_state   = r_state;

  spi_rx_fifo #(
    .DEPTH (RX_DEPTH),
    .W     (8)
  ) u_rx_fifo (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_push  (w_fifo_push),
    .i_data  (sfr_data_o),
    .i_pop   (rx_ready),
    .o_data  (rx_data),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty)
  );

endmodule

// File: tb/tb_spi_xfer_ctrl.sv
module tb_spi_xfer_ctrl;
  import spi_xfer_pkg::*;

  localparam int RX_DEPTH    = 4;
  localparam int TIMEOUT_CYC = 1024;
  localparam int IDLE_GAP    = 8;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       cfg_start = 1'b0;
  logic       cfg_cpol  = 1'b0;
  logic       cfg_cpha  = 1'b0;
  logic [1:0] cfg_div   = 2'd0;
  logic [2:0] cfg_ss    = 3'd0;
  logic       cfg_done;
  logic       tx_valid  = 1'b0;
  logic       tx_ready;
  logic [7:0] tx_data   = 8'h00;
  logic       tx_last   = 1'b0;
  logic       rx_valid;
  logic       rx_ready  = 1'b0;
  logic [7:0] rx_data;
  logic       busy;
  logic       err_timeout;
  logic [2:0] sfraddr_w;
  logic [2:0] sfraddr_r;
  logic       sfrwe;
  logic [7:0] spidata_i;
  logic [7:0] spssn_i;
  logic [7:0] sfr_data_o = 8'h00;
  logic       intspi     = 1'b0;
  state_t     dbg_state;

  spi_xfer_ctrl #(
    .RX_DEPTH    (RX_DEPTH),
    .TIMEOUT_CYC (TIMEOUT_CYC),
    .IDLE_GAP    (IDLE_GAP)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .cfg_start   (cfg_start),
    .cfg_cpol    (cfg_cpol),
    .cfg_cpha    (cfg_cpha),
    .cfg_div     (cfg_div),
    .cfg_ss      (cfg_ss),
    .cfg_done    (cfg_done),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .tx_data     (tx_data),
    .tx_last     (tx_last),
    .rx_valid    (rx_valid),
    .rx_ready    (rx_ready),
    .rx_data     (rx_data),
    .busy        (busy),
    .err_timeout (err_timeout),
    .sfraddr_w   (sfraddr_w),
    .sfraddr_r   (sfraddr_r),
    .sfrwe       (sfrwe),
    .spidata_i   (spidata_i),
    .spssn_i     (spssn_i),
    .sfr_data_o  (sfr_data_o),
    .intspi      (intspi),
    .dbg_state   (dbg_state)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // spi_ms stand-in: a data write starts a transfer, intspi rises slave_lat
  // cycles later with the received byte = sent byte ^ 0x99. Writing 0x00 to
  // status clears it; a fully deselected bus abandons any pending transfer.
  // ---------------------------------------------------------------------------
  logic       slave_en  = 1'b1;
  int         slave_lat = 12;
  logic       s_busy    = 1'b0;
  int         s_cnt     = 0;
  logic [7:0] s_byte    = 8'h00;

  always @(posedge clk) begin
    if (rst || spssn_i == 8'hFF) begin
      s_busy <= 1'b0;
      intspi <= 1'b0;
    end else begin
      if (sfrwe && sfraddr_w == 3'd3 && !s_busy) begin
        s_busy <= 1'b1;
        s_cnt  <= slave_lat;
        s_byte <= spidata_i;
      end else if (s_busy && s_cnt > 0) begin
        s_cnt <= s_cnt - 1;
      end else if (s_busy && slave_en && !intspi) begin
        intspi     <= 1'b1;
        sfr_data_o <= s_byte ^ 8'h99;
      end
      if (sfrwe && sfraddr_w == 3'd1 && spidata_i == 8'h00) begin
        intspi <= 1'b0;
        s_busy <= 1'b0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Scoreboard: RX bytes must come out in order, each equal to the expected
  // slave reply. Also every SFR write must last exactly two cycles.
  // ---------------------------------------------------------------------------
  logic [7:0] exp_q[$];
  int         n_rx    = 0;
  logic [7:0] last_rx = 8'h00;
  logic [10:0] run_key = '0;
  int          run_len = 0;

  always @(negedge clk) begin
    if (!rst && rx_valid && rx_ready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL rx_unexpected actual=0x%0h expected=none", rx_data);
      end else begin
        check("rx_data", rx_data, exp_q.pop_front());
      end
      last_rx = rx_data;
      n_rx++;
    end
  end

  always @(negedge clk) begin
    if (sfrwe && !rst) begin
      if (run_len > 0 && {sfraddr_w, spidata_i} == run_key) begin
        run_len++;
      end else begin
        if (run_len > 0) check("wr_len", run_len, 2);
        run_key = {sfraddr_w, spidata_i};
        run_len = 1;
      end
    end else begin
      if (run_len > 0) check("wr_len", run_len, 2);
      run_len = 0;
    end
  end

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  function automatic logic [7:0] sel_of(input logic [2:0] ss);
    logic [7:0] v;
    v     = 8'hFF;
    v[ss] = 1'b0;
    return v;
  endfunction

  task automatic set_rx_ready(input logic v);
    @(posedge clk);
    #1;
    rx_ready = v;
  endtask

  task automatic send_byte(input logic [7:0] d, input logic last,
                           input logic [7:0] sel, input bit expect_rx);
    bit got = 1'b0;
    tx_data  = d;
    tx_last  = last;
    tx_valid = 1'b1;
    for (int i = 0; i < 400 && !got; i++) begin
      @(negedge clk);
      if (tx_ready) got = 1'b1;
    end
    check("tx_accept", got, 1);
    if (got) begin
      if (expect_rx) exp_q.push_back(d ^ 8'h99);
      check("sel_at_load", spssn_i, sel);
    end
    @(posedge clk);
    #1;
    tx_valid = 1'b0;
    tx_last  = 1'b0;
  endtask

  task automatic finish_burst();
    int gap = 0;
    bit done = 1'b0;
    for (int i = 0; i < 3000 && !done; i++) begin
      @(negedge clk);
      if (!busy) done = 1'b1;
      else if (spssn_i == 8'hFF) gap++;
    end
    check("burst_end", done, 1);
    check("gap_len", gap, IDLE_GAP);
    check("ssn_idle", spssn_i, 8'hFF);
  endtask

  task automatic do_cfg(input logic cpol, input logic cpha,
                        input logic [1:0] div, input logic [2:0] ss);
    logic [7:0] ctl;
    bit done = 1'b0;
    ctl       = 8'h50 | {4'b0, cpol, cpha, 2'b00};
    cfg_cpol  = cpol;
    cfg_cpha  = cpha;
    cfg_div   = div;
    cfg_ss    = ss;
    cfg_start = 1'b1;
    @(negedge clk);
    cfg_start = 1'b0;
    check("cfg_ctl", {sfrwe, sfraddr_w, spidata_i}, {1'b1, 3'd0, ctl});
    repeat (4) @(negedge clk);
    check("cfg_div", {sfrwe, sfraddr_w, spidata_i}, {1'b1, 3'd2, 6'b0, div});
    for (int i = 0; i < 10 && !done; i++) begin
      @(negedge clk);
      if (cfg_done) done = 1'b1;
    end
    check("cfg_done", done, 1);
    check("cfg_err_clr", err_timeout, 0);
  endtask

  // ---------------------------------------------------------------------------
  // Configuration vector table (one row per clock)
  // ---------------------------------------------------------------------------
  typedef struct {
    logic       cfg_start;
    logic       tx_valid;
    logic       cpol;
    logic       cpha;
    logic [1:0] div;
    logic [2:0] ss;
    logic       e_sfrwe;
    logic [2:0] e_waddr;
    logic [7:0] e_wdata;
    logic [7:0] e_ssn;
    logic       e_done;
    logic       e_busy;
    logic       e_tx_ready;
  } vec_t;

  vec_t vecs[10];

  function automatic vec_t mk(input logic st, input logic tv, input logic cp, input logic ch,
                              input logic [1:0] dv, input logic [2:0] ss,
                              input logic we, input logic [2:0] wa, input logic [7:0] wd,
                              input logic dn);
    vec_t v;
    v.cfg_start = st;  v.tx_valid = tv;  v.cpol = cp;  v.cpha = ch;
    v.div = dv;        v.ss = ss;
    v.e_sfrwe = we;    v.e_waddr = wa;   v.e_wdata = wd;
    v.e_ssn = 8'hFF;   v.e_done = dn;    v.e_busy = 1'b0;  v.e_tx_ready = 1'b0;
    return v;
  endfunction

  // ---------------------------------------------------------------------------
  // Test sequence
  // ---------------------------------------------------------------------------
  initial begin
    logic [7:0] sel;
    logic [2:0] ss_v;
    logic [1:0] mv;
    int         rx0;
    int         cyc;
    bit         hit;

    // tx_valid before configuration must not start a burst
    vecs[0] = mk(1'b0, 1'b1, 1'b0, 1'b0, 2'd3, 3'd0, 1'b0, 3'd0, 8'h00, 1'b0);
    // mode 0, div 3, ss 0 (cfg_start wins over tx_valid)
    vecs[1] = mk(1'b1, 1'b1, 1'b0, 1'b0, 2'd3, 3'd0, 1'b1, 3'd0, 8'h50, 1'b0);
    // second cfg_start while configuring is ignored
    vecs[2] = mk(1'b1, 1'b0, 1'b1, 1'b1, 2'd0, 3'd5, 1'b1, 3'd0, 8'h50, 1'b0);
    vecs[3] = mk(1'b0, 1'b0, 1'b1, 1'b1, 2'd0, 3'd5, 1'b1, 3'd1, 8'h01, 1'b0);
    vecs[4] = mk(1'b0, 1'b0, 1'b1, 1'b1, 2'd0, 3'd5, 1'b1, 3'd1, 8'h01, 1'b0);
    vecs[5] = mk(1'b0, 1'b0, 1'b1, 1'b1, 2'd0, 3'd5, 1'b1, 3'd2, 8'h03, 1'b0);
    vecs[6] = mk(1'b0, 1'b0, 1'b1, 1'b1, 2'd0, 3'd5, 1'b1, 3'd2, 8'h03, 1'b0);
    vecs[7] = mk(1'b0, 1'b0, 1'b1, 1'b1, 2'd0, 3'd5, 1'b0, 3'd0, 8'h00, 1'b1);
    vecs[8] = mk(1'b0, 1'b0, 1'b0, 1'b0, 2'd3, 3'd0, 1'b0, 3'd0, 8'h00, 1'b1);
    vecs[9] = mk(1'b0, 1'b0, 1'b0, 1'b0, 2'd3, 3'd0, 1'b0, 3'd0, 8'h00, 1'b1);

    // Reset values
    repeat (3) @(negedge clk);
    check("rst_sfrwe", sfrwe, 0);
    check("rst_addr", {sfraddr_w, sfraddr_r}, 6'd0);
    check("rst_wdata", spidata_i, 8'h00);
    check("rst_ssn", spssn_i, 8'hFF);
    check("rst_flags", {tx_ready, rx_valid, busy, cfg_done, err_timeout}, 5'b0);
    check("rst_state", dbg_state, S_IDLE);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);

    // Configuration table
    for (int i = 0; i < 10; i++) begin
      cfg_start = vecs[i].cfg_start;
      tx_valid  = vecs[i].tx_valid;
      cfg_cpol  = vecs[i].cpol;
      cfg_cpha  = vecs[i].cpha;
      cfg_div   = vecs[i].div;
      cfg_ss    = vecs[i].ss;
      @(negedge clk);
      check($sformatf("vec%0d", i),
            {sfrwe, sfraddr_w, spidata_i, spssn_i, cfg_done, busy, tx_ready},
            {vecs[i].e_sfrwe, vecs[i].e_waddr, vecs[i].e_wdata, vecs[i].e_ssn,
             vecs[i].e_done, vecs[i].e_busy, vecs[i].e_tx_ready});
    end

    // Single byte 0xA5 -> slave answers 0x3C
    set_rx_ready(1'b1);
    @(negedge clk);
    send_byte(8'hA5, 1'b1, 8'hFE, 1'b1);
    finish_burst();
    check("rx_a5", last_rx, 8'h3C);
    check("rx_drain0", exp_q.size(), 0);

    // 4-byte bursts in all four modes, different select each time
    for (int m = 0; m < 4; m++) begin
      mv   = 2'(m);
      ss_v = 3'(m + 1);
      sel  = sel_of(ss_v);
      do_cfg(mv[1], mv[0], mv, ss_v);
      for (int b = 1; b <= 4; b++) begin
        send_byte(8'(b), (b == 4), sel, 1'b1);
      end
      finish_burst();
      check($sformatf("rx_drain_m%0d", m), exp_q.size(), 0);
    end

    // Burst of 6 with the host not popping: 4 bytes fill the FIFO, the 5th
    // stalls in READ, nothing is lost once the host drains.
    sel = sel_of(3'd4);
    set_rx_ready(1'b0);
    rx0 = n_rx;
    for (int b = 0; b < 5; b++) begin
      send_byte(8'h10 + 8'(b), 1'b0, sel, 1'b1);
    end
    tx_data  = 8'h15;
    tx_last  = 1'b1;
    tx_valid = 1'b1;
    repeat (60) @(negedge clk);
    check("stall_state", dbg_state, S_READ);
    check("stall_raddr", sfraddr_r, 3'd3);
    check("stall_rx_valid", rx_valid, 1);
    check("stall_tx_ready", tx_ready, 0);
    check("stall_ssn", spssn_i, sel);
    check("stall_popped", n_rx - rx0, 0);
    set_rx_ready(1'b1);
    send_byte(8'h15, 1'b1, sel, 1'b1);
    finish_burst();
    check("stall_total", n_rx - rx0, 6);
    check("stall_drain", exp_q.size(), 0);

    // No slave reply: timeout after TIMEOUT_CYC wait cycles (+1 LOAD, +2 write)
    do_cfg(1'b0, 1'b0, 2'd3, 3'd0);
    slave_en = 1'b0;
    rx0 = n_rx;
    send_byte(8'h77, 1'b0, 8'hFE, 1'b0);
    cyc = 0;
    hit = 1'b0;
    for (int i = 0; i < 1200 && !hit; i++) begin
      @(negedge clk);
      cyc++;
      if (err_timeout) hit = 1'b1;
    end
    check("timeout_seen", hit, 1);
    check("timeout_cyc", cyc, TIMEOUT_CYC + 3);
    finish_burst();
    check("timeout_sticky", err_timeout, 1);
    check("timeout_no_rx", {rx_valid, 8'(n_rx - rx0)}, 9'd0);
    slave_en = 1'b1;
    do_cfg(1'b0, 1'b0, 2'd3, 3'd0);

    // Reset while waiting for intspi, with one unread byte in the FIFO
    set_rx_ready(1'b0);
    send_byte(8'h5A, 1'b1, 8'hFE, 1'b1);
    finish_burst();
    check("pre_rst_rx_valid", rx_valid, 1);
    slave_lat = 200;
    send_byte(8'h6B, 1'b1, 8'hFE, 1'b0);
    hit = 1'b0;
    for (int i = 0; i < 20 && !hit; i++) begin
      @(negedge clk);
      if (dbg_state == S_WAIT_INT) hit = 1'b1;
    end
    check("reach_wait_int", hit, 1);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("mid_rst_ssn", spssn_i, 8'hFF);
    check("mid_rst_flags", {rx_valid, cfg_done, sfrwe, busy}, 4'b0);
    check("mid_rst_state", dbg_state, S_IDLE);
    exp_q.delete();
    #1;
    rst = 1'b0;
    slave_lat = 12;
    set_rx_ready(1'b1);
    repeat (3) @(negedge clk);
    check("post_rst_rx_valid", rx_valid, 0);
    check("post_rst_cfg_done", cfg_done, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2_000_000;
    n_errors++;
    $display("FAIL watchdog actual=timeout expected=finish");
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/spi_xfer_ctrl.md
# spi_xfer_ctrl

Register-level transfer controller that sits directly upstream of `spi_ms` and drives its SFR write/read port, slave-select bus and interrupt. Turns a byte stream with a `last` marker into SPI bursts: programs mode/divider once per configuration, asserts one slave select, writes each byte to the data register, waits for `intspi`, reads back the received byte and acknowledges it. Received bytes go to a small RX FIFO for the host.

## Interface
- `RX_DEPTH`, 4: RX FIFO entries, power of two, ≥2
- `TIMEOUT_CYC`, 1024: max clk cycles waited for `intspi` per byte
- `IDLE_GAP`, 8: min clk cycles with all selects high between bursts
---
- `clk` in 1: single clock, shared with `spi_ms`
- `rst` in 1: synchronous, active-high reset
- `cfg_start` in 1: pulse; program `spi_ms` from `cfg_*`
- `cfg_cpol`, `cfg_cpha` in 1 each: SPI mode
- `cfg_div` in 2: clock divider code (3 = clk/16)
- `cfg_ss` in 3: index of slave select to assert
- `cfg_done` out 1: level; configuration valid
- `tx_valid`, `tx_ready` in/out 1: TX byte handshake
- `tx_data` in 8: byte to send; `tx_last` in 1: deassert select after this byte
- `rx_valid`, `rx_ready` out/in 1: RX FIFO pop handshake; `rx_data` out 8
- `busy` out 1: burst in progress; `err_timeout` out 1: sticky
- `sfraddr_w`, `sfraddr_r` out 3; `sfrwe` out 1; `spidata_i` out 8; `spssn_i` out 8: to `spi_ms`
- `sfr_data_o` in 8; `intspi` in 1: from `spi_ms`

## Operation
- SFR map: 0 = control (bit6 SPE, bit4 MSTR, bit3 CPOL, bit2 CPHA), 1 = status (write 0x00 clears transfer flag / `intspi`), 2 = divider, 3 = data.
- Every SFR write: address+data held, `sfrwe`=1, exactly 2 cycles; else `sfrwe`=0. Every read: `sfraddr_r` held 2 cycles, `sfr_data_o` sampled at end of 2nd cycle.
- FSM: IDLE → (cfg_start) CFG_CTL → CFG_STS → CFG_DIV → IDLE, `cfg_done`=1. Control byte = `{1'b0,1,1'b0,1,cpol,cpha,2'b00}`; status 0x01 (enable); divider `{6'b0,cfg_div}`.
- IDLE with `cfg_done` and `tx_valid` → SS_ON (`spssn_i` bit `cfg_ss` low, 2 cycles) → LOAD (`tx_ready`=1 one cycle, byte latched, write to addr 3) → WAIT_INT → READ (addr 3) → ACK (write 0 to addr 1) → if latched `last`: SS_HOLD (2 cycles) → GAP (`IDLE_GAP` cycles, all selects high) → IDLE; else → LOAD (waits for `tx_valid`, select stays low).
- `tx_ready` high only in LOAD single cycle with `tx_valid`; never in IDLE/CFG.
- `cfg_start` accepted only in IDLE; ignored otherwise (no error).
- RX FIFO full on READ entry: stay in READ until a slot frees; no byte dropped.
- WAIT_INT counter reaches `TIMEOUT_CYC`: `err_timeout`=1, go to SS_HOLD; remaining bytes of burst not sent (next TX byte starts a new burst). `err_timeout` cleared by `rst` or accepted `cfg_start`.
- Simultaneous RX push and pop: both occur, count unchanged.

## Timing
- Reset values: `sfrwe`=0, `sfraddr_w`=`sfraddr_r`=0, `spidata_i`=0, `spssn_i`=8'hFF, `tx_ready`=0, `rx_valid`=0, `busy`=0, `cfg_done`=0, `err_timeout`=0; FIFO empty; FSM IDLE.
- `rst` mid-burst: next cycle all selects high, `sfrwe`=0, FIFO flushed; `spi_ms` re-programmed only via new `cfg_start`.
- Configuration: 6 cycles from `cfg_start` to `cfg_done`.
- Per byte overhead: 2 (write) + wait + 2 (read) + 2 (ack); `intspi` sampled registered (1-cycle delay).
- `rx_valid` asserted cycle after READ completes; FIFO output registered (`rx_data` valid with `rx_valid`).
- `busy`=1 from SS_ON entry through end of GAP.

## Structure
- Package `spi_xfer_pkg`: SFR address constants (`SFR_CTL`, `SFR_STS`, `SFR_DIV`, `SFR_DAT`), control bit positions, FSM state enum.
- Sub-module `spi_rx_fifo` (synchronous, `RX_DEPTH`, 8-bit, push/pop/full/empty, pointer wrap via extra MSB).

## Test plan
- Config mode 0, div 3, ss 0 → writes 0x50@0, 0x01@1, 0x03@2, each 2 cycles; `cfg_done`=1 after 6 cycles.
- Single byte 0xA5 `last`=1 with `spi_ms` slave returning 0x3C → `spssn_i`=8'hFE during burst, 0xA5@3, `rx_data`=0x3C, then 8'hFF for ≥8 cycles.
- 4-byte burst (0x01..0x04, last on 4th), all four modes → select low throughout, RX bytes match slave data in order.
- Burst of 6 with `rx_ready`=0 → 4 bytes captured, controller stalls in READ; releasing `rx_ready` completes 6 bytes, none lost.
- No slave / `intspi` held 0 → `err_timeout`=1 after 1024 cycles, select released; `cfg_start` clears it.
- `rst` asserted in WAIT_INT → next cycle `spssn_i`=8'hFF, `rx_valid`=0, `cfg_done`=0.
